// File: rtl/cubic_grad_eval.sv
// Gradient-descent function unit: evaluates a fixed Q24.8 cubic, its derivative and the
// learning-rate-scaled step by Horner's rule on one shared signed 32x32 multiplier.
module cubic_grad_eval #(
  parameter logic [31:0] C0            = 32'h00000400,
  parameter logic [31:0] C1            = 32'hFFFFFC00,
  parameter logic [31:0] C2            = 32'h00000100,
  parameter logic [31:0] C3            = 32'h00000000,
  parameter logic [31:0] LEARNING_RATE = 32'h00000080
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_func,
  input  logic [31:0] x_in,
  output logic [63:0] value,
  output logic [31:0] gradient,
  output logic [31:0] x_diff_out,
  output logic        func_done,
  output logic        overflow
);

  typedef enum logic [3:0] {
    IDLE, CAPTURE, VAL1, VAL2, VAL3, GRAD1, GRAD2, STEP, DONE
  } state_t;

  localparam logic [63:0] C0_EXT = {{32{C0[31]}}, C0};
  localparam logic [63:0] C1_EXT = {{32{C1[31]}}, C1};
  localparam logic [63:0] C2_EXT = {{32{C2[31]}}, C2};
  localparam logic [63:0] C3_EXT = {{32{C3[31]}}, C3};
  localparam logic [63:0] C3_X3  = C3_EXT + C3_EXT + C3_EXT;
  localparam logic [63:0] C2_X2  = C2_EXT + C2_EXT;
  localparam logic        C3_X3_TRUNC = (C3_X3 != {{32{C3_X3[31]}}, C3_X3[31:0]});

  state_t      r_state;
  logic [31:0] r_x;
  logic [63:0] r_acc;
  logic [63:0] r_val;
  logic [31:0] r_grad;
  logic [31:0] r_step;
  logic        r_ovf;

  logic signed [31:0] w_mulA;
  logic signed [31:0] w_mulB;
  logic signed [63:0] w_prod;
  logic signed [63:0] w_mul;
  logic [63:0]        w_addend;
  logic [63:0]        w_sum;
  logic [31:0]        w_sat;
  logic               w_accTrunc;
  logic               w_truncOvf;
  logic               w_addOvf;
  logic               w_satOvf;

  // The multiplier only sees the low 32 bits of the accumulator; losing information there is an overflow.
  assign w_accTrunc = (r_acc != {{32{r_acc[31]}}, r_acc[31:0]});

  always_comb begin
    w_mulA     = '0;
    w_mulB     = r_x;
    w_addend   = '0;
    w_truncOvf = 1'b0;
    case (r_state)
      VAL1:  begin w_mulA = C3;          w_addend = C2_EXT; end
      VAL2:  begin w_mulA = r_acc[31:0]; w_addend = C1_EXT; w_truncOvf = w_accTrunc; end
      VAL3:  begin w_mulA = r_acc[31:0]; w_addend = C0_EXT; w_truncOvf = w_accTrunc; end
      GRAD1: begin w_mulA = C3_X3[31:0]; w_addend = C2_X2;  w_truncOvf = C3_X3_TRUNC; end
      GRAD2: begin w_mulA = r_acc[31:0]; w_addend = C1_EXT; w_truncOvf = w_accTrunc; end
      STEP:  begin w_mulA = r_grad;      w_mulB = LEARNING_RATE; end
      default: ;
    endcase
  end

  assign w_prod   = w_mulA * w_mulB;
  assign w_mul    = w_prod >>> 8;
  assign w_sum    = w_mul + w_addend;
  assign w_addOvf = (w_mul[63] == w_addend[63]) && (w_sum[63] != w_mul[63]);
  assign w_satOvf = !((&w_sum[63:31]) || (~|w_sum[63:31]));
  assign w_sat    = !w_satOvf ? w_sum[31:0] : (w_sum[63] ? 32'h80000000 : 32'h7FFFFFFF);

  // Results are published one edge after entering DONE so func_done follows the request by 8 edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_x        <= '0;
      r_acc      <= '0;
      r_val      <= '0;
      r_grad     <= '0;
      r_step     <= '0;
      r_ovf      <= 1'b0;
      value      <= '0;
      gradient   <= '0;
      x_diff_out <= '0;
      func_done  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_func) begin
            r_x     <= x_in;
            r_ovf   <= 1'b0;
            r_state <= CAPTURE;
          end
        end
        DONE: begin
          if (!start_func) begin
            func_done <= 1'b0;
            r_state   <= IDLE;
          end else if (!func_done) begin
            value      <= r_val;
            gradient   <= r_grad;
            x_diff_out <= r_step;
            overflow   <= r_ovf;
            func_done  <= 1'b1;
          end
        end
        default: begin
          if (!start_func) begin
            r_state <= IDLE;
          end else begin
            case (r_state)
              CAPTURE: r_state <= VAL1;
              VAL1: begin
                r_acc   <= w_sum;
                r_ovf   <= r_ovf | w_addOvf;
                r_state <= VAL2;
              end
              VAL2: begin
                r_acc   <= w_sum;
                r_ovf   <= r_ovf | w_addOvf | w_truncOvf;
                r_state <= VAL3;
              end
              VAL3: begin
                r_val   <= w_sum;
                r_ovf   <= r_ovf | w_addOvf | w_truncOvf;
                r_state <= GRAD1;
              end
              GRAD1: begin
                r_acc   <= w_sum;
                r_ovf   <= r_ovf | w_addOvf | w_truncOvf;
                r_state <= GRAD2;
              end
              GRAD2: begin
                r_grad  <= w_sat;
                r_ovf   <= r_ovf | w_addOvf | w_truncOvf | w_satOvf;
                r_state <= STEP;
              end
              STEP: begin
                r_step  <= w_sat;
                r_ovf   <= r_ovf | w_satOvf;
                r_state <= DONE;
              end
              default: r_state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cubic_grad_eval.sv
// Scoreboard bench for cubic_grad_eval: default quadratic instance plus a pure-cubic instance.
module tb_cubic_grad_eval;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        startA = 1'b0;
  logic [31:0] xA = '0;
  logic [63:0] valueA;
  logic [31:0] gradA, stepA;
  logic        doneA, ovfA;
  logic        startB = 1'b0;
  logic [31:0] xB = '0;
  logic [63:0] valueB;
  logic [31:0] gradB, stepB;
  logic        doneB, ovfB;

  typedef struct packed {
    logic [63:0] value;
    logic [31:0] grad;
    logic [31:0] step;
    logic        ovf;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cubic_grad_eval dutA (
    .clk(clk), .rst_n(rst_n), .start_func(startA), .x_in(xA),
    .value(valueA), .gradient(gradA), .x_diff_out(stepA),
    .func_done(doneA), .overflow(ovfA)
  );

  cubic_grad_eval #(.C0(32'h0), .C1(32'h0), .C2(32'h0), .C3(32'h100)) dutB (
    .clk(clk), .rst_n(rst_n), .start_func(startB), .x_in(xB),
    .value(valueB), .gradient(gradB), .x_diff_out(stepB),
    .func_done(doneB), .overflow(ovfB)
  );

  // Expected results enter the queue as the request is raised.
  task automatic pushReq(input bit onB, input logic [31:0] x, input logic [63:0] v,
                         input logic [31:0] g, input logic [31:0] s, input logic o);
    exp_t e;
    e.value = v; e.grad = g; e.step = s; e.ovf = o;
    expQ.push_back(e);
    @(negedge clk);
    if (onB) begin xB = x; startB = 1'b1; end
    else begin xA = x; startA = 1'b1; end
  endtask

  // Edge N is the first posedge after the request; lat is the edge count after N, -1 on timeout.
  task automatic waitDone(input bit onB, output int lat);
    lat = -1;
    @(posedge clk);
    #1;
    if (onB) xB = 32'h5A5A5A5A; else xA = 32'hA5A5A5A5;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if ((onB ? doneB : doneA) === 1'b1) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({valueA, gradA, stepA, doneA, ovfA} !== '0) begin
      errors++; $display("[TB] FAIL reset_A got %h_%h_%h_%b_%b want all zero", valueA, gradA, stepA, doneA, ovfA);
    end
    checks++;
    if ({valueB, gradB, stepB, doneB, ovfB} !== '0) begin
      errors++; $display("[TB] FAIL reset_B got %h_%h_%h_%b_%b want all zero", valueB, gradB, stepB, doneB, ovfB);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat; exp_t e;
    pushReq(1'b0, 32'h0, 64'h400, 32'hFFFFFC00, 32'hFFFFFE00, 1'b0);
    waitDone(1'b0, lat);
    e = expQ.pop_front();
    checks++;
    if (lat != 8) begin errors++; $display("[TB] FAIL basic_latency got %0d want 8", lat); end
    checks++;
    if ({valueA, gradA, stepA, ovfA} !== e) begin
      errors++; $display("[TB] FAIL basic_result got %h want %h", {valueA, gradA, stepA, ovfA}, e);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (doneA !== 1'b1 || {valueA, gradA, stepA, ovfA} !== e) begin
      errors++; $display("[TB] FAIL basic_hold got done=%b %h want done=1 %h", doneA, {valueA, gradA, stepA, ovfA}, e);
    end
    @(negedge clk);
    startA = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (doneA !== 1'b0 || {valueA, gradA, stepA, ovfA} !== e) begin
      errors++; $display("[TB] FAIL basic_release got done=%b %h want done=0 %h", doneA, {valueA, gradA, stepA, ovfA}, e);
    end
  endtask

  task automatic test_back_to_back();
    int lat; exp_t e;
    pushReq(1'b0, 32'h500, 64'h900, 32'h600, 32'h300, 1'b0);
    waitDone(1'b0, lat);
    e = expQ.pop_front();
    checks++;
    if (lat != 8 || {valueA, gradA, stepA, ovfA} !== e) begin
      errors++; $display("[TB] FAIL x5_result lat=%0d got %h want lat=8 %h", lat, {valueA, gradA, stepA, ovfA}, e);
    end
    @(negedge clk);
    startA = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (doneA !== 1'b0) begin errors++; $display("[TB] FAIL gap_done got %b want 0", doneA); end
    pushReq(1'b0, 32'h200, 64'h0, 32'h0, 32'h0, 1'b0);
    waitDone(1'b0, lat);
    e = expQ.pop_front();
    checks++;
    if (lat != 8 || {valueA, gradA, stepA, ovfA} !== e) begin
      errors++; $display("[TB] FAIL x2_result lat=%0d got %h want lat=8 %h", lat, {valueA, gradA, stepA, ovfA}, e);
    end
    @(negedge clk);
    startA = 1'b0;
  endtask

  task automatic test_overflow();
    int lat; exp_t e;
    pushReq(1'b0, 32'h7FFFFFFF, 64'h003FFFFDFF000404, 32'h7FFFFFFF, 32'h3FFFFFFF, 1'b1);
    waitDone(1'b0, lat);
    e = expQ.pop_front();
    checks++;
    if (lat != 8 || {valueA, gradA, stepA, ovfA} !== e) begin
      errors++; $display("[TB] FAIL sat_result lat=%0d got %h want lat=8 %h", lat, {valueA, gradA, stepA, ovfA}, e);
    end
    @(negedge clk);
    startA = 1'b0;
    pushReq(1'b0, 32'h0, 64'h400, 32'hFFFFFC00, 32'hFFFFFE00, 1'b0);
    waitDone(1'b0, lat);
    e = expQ.pop_front();
    checks++;
    if (lat != 8 || {valueA, gradA, stepA, ovfA} !== e) begin
      errors++; $display("[TB] FAIL ovf_clear lat=%0d got %h want lat=8 %h", lat, {valueA, gradA, stepA, ovfA}, e);
    end
    @(negedge clk);
    startA = 1'b0;
  endtask

  task automatic test_cubic();
    int lat; exp_t e;
    pushReq(1'b1, 32'hFFFFFE00, 64'hFFFFFFFFFFFFF800, 32'h00000C00, 32'h00000600, 1'b0);
    waitDone(1'b1, lat);
    e = expQ.pop_front();
    checks++;
    if (lat != 8 || {valueB, gradB, stepB, ovfB} !== e) begin
      errors++; $display("[TB] FAIL cubic_result lat=%0d got %h want lat=8 %h", lat, {valueB, gradB, stepB, ovfB}, e);
    end
    @(negedge clk);
    startB = 1'b0;
  endtask

  task automatic test_abort();
    int lat; exp_t e; bit sawDone;
    @(negedge clk);
    xA = 32'h500;
    startA = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    startA = 1'b0;
    sawDone = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (doneA !== 1'b0) sawDone = 1'b1;
    end
    checks++;
    if (sawDone) begin errors++; $display("[TB] FAIL abort_done got 1 want 0"); end
    checks++;
    if ({valueA, gradA, stepA, ovfA} !== {64'h400, 32'hFFFFFC00, 32'hFFFFFE00, 1'b0}) begin
      errors++; $display("[TB] FAIL abort_hold got %h want %h", {valueA, gradA, stepA, ovfA},
                         {64'h400, 32'hFFFFFC00, 32'hFFFFFE00, 1'b0});
    end
    pushReq(1'b0, 32'h500, 64'h900, 32'h600, 32'h300, 1'b0);
    waitDone(1'b0, lat);
    e = expQ.pop_front();
    checks++;
    if (lat != 8 || {valueA, gradA, stepA, ovfA} !== e) begin
      errors++; $display("[TB] FAIL abort_retry lat=%0d got %h want lat=8 %h", lat, {valueA, gradA, stepA, ovfA}, e);
    end
    @(negedge clk);
    startA = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int lat; exp_t e; bit sawDone;
    @(negedge clk);
    xA = 32'h500;
    startA = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    startA = 1'b0;
    #1;
    checks++;
    if ({valueA, gradA, stepA, doneA, ovfA} !== '0) begin
      errors++; $display("[TB] FAIL midreset_clear got %h_%h_%h_%b_%b want all zero", valueA, gradA, stepA, doneA, ovfA);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sawDone = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (doneA !== 1'b0) sawDone = 1'b1;
    end
    checks++;
    if (sawDone) begin errors++; $display("[TB] FAIL midreset_idle got done=1 want 0"); end
    pushReq(1'b0, 32'h0, 64'h400, 32'hFFFFFC00, 32'hFFFFFE00, 1'b0);
    waitDone(1'b0, lat);
    e = expQ.pop_front();
    checks++;
    if (lat != 8 || {valueA, gradA, stepA, ovfA} !== e) begin
      errors++; $display("[TB] FAIL midreset_retry lat=%0d got %h want lat=8 %h", lat, {valueA, gradA, stepA, ovfA}, e);
    end
    @(negedge clk);
    startA = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_cubic();
    test_abort();
    test_reset_midrun();
    checks++;
    if (expQ.size() != 0) begin
      errors++; $display("[TB] FAIL scoreboard_drain got %0d left want 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
